// File: rtl/intf_reduce.sv
// intf_reduce: N-channel bitwise reduction unit with buffered handshakes.
//
// Each input channel owns a DEPTH-entry FIFO. When every channel holds a word
// and the 2-entry output FIFO has room, one word is popped from each channel.
// The selected bitwise op is applied to those words and the result is queued.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_data     NCH*DW  channel i at [i*DW +: DW]
//   in_en       NCH     per-channel push strobe
//   in_rdy      NCH     per-channel FIFO not full
//   mode_value  2       00 OR, 01 AND, 10 XOR, 11 OR
//   mode_en     1       mode write strobe
//   mode_rdy    1       mode may be written (unit idle)
//   y_en        1       pop result
//   y_data      DW      head of result FIFO, 0 when empty
//   y_rdy       1       result FIFO not empty
//   fire_count  16      saturating fire counter (only with INTF_REDUCE_STATS_EN)
//
// Build option: define INTF_REDUCE_STATS_EN to add the fire_count port.
// The counter is cleared by reset and by every accepted mode write.

module intf_reduce #(
   parameter int NCH   = 2,
   parameter int DW    = 8,
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH*DW-1:0] in_data,
   input  logic [NCH-1:0]    in_en,
   output logic [NCH-1:0]    in_rdy,
   input  logic [1:0]        mode_value,
   input  logic              mode_en,
   output logic              mode_rdy,
   input  logic              y_en,
   output logic [DW-1:0]     y_data,
   output logic              y_rdy
`ifdef INTF_REDUCE_STATS_EN
   ,
   output logic [15:0]       fire_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   // Held low through reset and for the first edge after release, so all
   // ready outputs stay low while rst_n is asserted.
   logic active;

   logic [DW-1:0] in_mem [NCH][DEPTH];
   logic [AW-1:0] rd_ptr [NCH];
   logic [AW-1:0] wr_ptr [NCH];
   logic [AW:0]   cnt    [NCH];

   logic [NCH-1:0] not_empty;
   logic [NCH-1:0] push;

   logic [DW-1:0] out_mem [2];
   logic          out_wr;
   logic          out_rd;
   logic [1:0]    out_cnt;

   logic [1:0]    mode;
   logic          fire;
   logic          pop_y;
   logic [DW-1:0] result;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         not_empty[i] = (cnt[i] != '0);
         in_rdy[i]    = active && (cnt[i] != FULL_CNT);
      end
   end

   assign push     = in_en & in_rdy;
   assign fire     = (&not_empty) && (out_cnt != 2'd2);
   assign y_rdy    = (out_cnt != 2'd0);
   assign y_data   = y_rdy ? out_mem[out_rd] : '0;
   assign pop_y    = y_en && y_rdy;
   assign mode_rdy = active && !(|not_empty) && (out_cnt == 2'd0) && !fire;

   // Reserved mode 11 falls into the OR default.
   always_comb begin
      result = in_mem[0][rd_ptr[0]];
      for (int i = 1; i < NCH; i++) begin
         case (mode)
            2'b01:   result = result & in_mem[i][rd_ptr[i]];
            2'b10:   result = result ^ in_mem[i][rd_ptr[i]];
            default: result = result | in_mem[i][rd_ptr[i]];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (push[i]) in_mem[i][wr_ptr[i]] <= in_data[i*DW +: DW];
      end
      if (fire) out_mem[out_wr] <= result;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= 1'b0;
         mode    <= 2'b00;
         out_wr  <= 1'b0;
         out_rd  <= 1'b0;
         out_cnt <= 2'd0;
         for (int i = 0; i < NCH; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            cnt[i]    <= '0;
         end
      end else begin
         active <= 1'b1;
         for (int i = 0; i < NCH; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
            if (fire)    rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            case ({push[i], fire})
               2'b10:   cnt[i] <= cnt[i] + CNT_ONE;
               2'b01:   cnt[i] <= cnt[i] - CNT_ONE;
               default: cnt[i] <= cnt[i];
            endcase
         end
         if (fire)  out_wr <= ~out_wr;
         if (pop_y) out_rd <= ~out_rd;
         case ({fire, pop_y})
            2'b10:   out_cnt <= out_cnt + 2'd1;
            2'b01:   out_cnt <= out_cnt - 2'd1;
            default: out_cnt <= out_cnt;
         endcase
         if (mode_en && mode_rdy) mode <= mode_value;
      end
   end

`ifdef INTF_REDUCE_STATS_EN
   // A mode write and a fire never coincide: mode_rdy requires !fire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fire_count <= 16'd0;
      end else if (mode_en && mode_rdy) begin
         fire_count <= 16'd0;
      end else if (fire && (fire_count != 16'hFFFF)) begin
         fire_count <= fire_count + 16'd1;
      end
   end
`endif

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            assert (!(in_en[i] && !in_rdy[i]))
               else $warning("intf_reduce: push on channel %0d while not ready is dropped", i);
         end
      end
   end
`endif

endmodule

// File: tb/tb_intf_reduce.sv
// Directed bench for intf_reduce (NCH=2, DW=8, DEPTH=2).
// Inputs are driven and outputs sampled on the falling edge.

module tb_intf_reduce;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] in_data = '0;
   logic [1:0]  in_en = '0;
   logic [1:0]  in_rdy;
   logic [1:0]  mode_value = '0;
   logic        mode_en = 1'b0;
   logic        mode_rdy;
   logic        y_en = 1'b0;
   logic [7:0]  y_data;
   logic        y_rdy;
`ifdef INTF_REDUCE_STATS_EN
   logic [15:0] fire_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   intf_reduce #(.NCH(2), .DW(8), .DEPTH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_en      (in_en),
      .in_rdy     (in_rdy),
      .mode_value (mode_value),
      .mode_en    (mode_en),
      .mode_rdy   (mode_rdy),
      .y_en       (y_en),
      .y_data     (y_data),
      .y_rdy      (y_rdy)
`ifdef INTF_REDUCE_STATS_EN
      ,
      .fire_count (fire_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [1:0] en, input logic [7:0] d0, input logic [7:0] d1);
      in_en   = en;
      in_data = {d1, d0};
      tick();
      in_en   = '0;
   endtask

   task automatic write_mode(input logic [1:0] m);
      mode_value = m;
      mode_en    = 1'b1;
      tick();
      mode_en    = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      chk({tag, "_rdy"}, y_rdy, 1);
      chk(tag, y_data, exp);
      y_en = 1'b1;
      tick();
      y_en = 1'b0;
   endtask

   initial begin
      // reset
      repeat (3) @(negedge clk);
      chk("rst_in_rdy", in_rdy, 2'b00);
      chk("rst_y_rdy", y_rdy, 0);
      chk("rst_y_data", y_data, 8'h00);
      chk("rst_mode_rdy", mode_rdy, 0);
      rst_n = 1'b1;
      tick();
      chk("rel_in_rdy", in_rdy, 2'b11);
      chk("rel_mode_rdy", mode_rdy, 1);
`ifdef INTF_REDUCE_STATS_EN
      chk("rel_fire_count", fire_count, 16'd0);
`endif

      // basic OR with one-cycle latency
      drive(2'b11, 8'h0F, 8'hF0);
      chk("or_not_yet", y_rdy, 0);
      tick();
      chk("or_mode_busy", mode_rdy, 0);
      pop_check("or_ff", 8'hFF);
      chk("or_popped", y_rdy, 0);
`ifdef INTF_REDUCE_STATS_EN
      chk("stat_one", fire_count, 16'd1);
`endif

      // fill everything, overflow push dropped, drain in order
      for (int j = 1; j <= 4; j++) drive(2'b11, 8'(j), 8'(j << 4));
      chk("full_in_rdy", in_rdy, 2'b00);
      drive(2'b11, 8'h05, 8'h50);
      chk("full_hold", in_rdy, 2'b00);
      y_en = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         chk("drain_rdy", y_rdy, 1);
         chk($sformatf("drain_%0d", j), y_data, 8'(j * 8'h11));
         tick();
      end
      y_en = 1'b0;
      chk("drain_empty", y_rdy, 0);
      chk("drain_in_rdy", in_rdy, 2'b11);

      // skewed channels
      drive(2'b01, 8'hA1, 8'h00);
      drive(2'b01, 8'hA2, 8'h00);
      chk("skew_ch0_full", in_rdy, 2'b10);
      tick();
      tick();
      chk("skew_wait", y_rdy, 0);
      drive(2'b10, 8'h00, 8'h0F);
      chk("skew_not_yet", y_rdy, 0);
      tick();
      chk("skew_rdy", y_rdy, 1);
      drive(2'b01, 8'hA3, 8'h00);
      chk("skew_ch0_refill", in_rdy, 2'b10);
      pop_check("skew_af", 8'hAF);
      chk("skew_single", y_rdy, 0);

      // mode write blocked with data in flight
      drive(2'b10, 8'h00, 8'h00);
      tick();
      chk("blk_mode_rdy", mode_rdy, 0);
      write_mode(2'b10);
      pop_check("blk_a2", 8'hA2);
      drive(2'b10, 8'h00, 8'h0F);
      tick();
      pop_check("blk_still_or", 8'hAF);
      chk("idle_mode_rdy", mode_rdy, 1);

      // XOR, AND, reserved
      write_mode(2'b10);
`ifdef INTF_REDUCE_STATS_EN
      chk("stat_clr", fire_count, 16'd0);
`endif
      drive(2'b11, 8'hAA, 8'hFF);
      tick();
      pop_check("xor_55", 8'h55);
      write_mode(2'b01);
      drive(2'b11, 8'hAA, 8'hFF);
      tick();
      pop_check("and_aa", 8'hAA);
      write_mode(2'b11);
      drive(2'b11, 8'h0F, 8'hF1);
      tick();
      pop_check("rsvd_or", 8'hFF);

      // async reset with results queued
      write_mode(2'b01);
      drive(2'b11, 8'h03, 8'h01);
      drive(2'b11, 8'h07, 8'h06);
      tick();
      tick();
      chk("pre_rst_rdy", y_rdy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_y_rdy", y_rdy, 0);
      chk("arst_y_data", y_data, 8'h00);
      chk("arst_in_rdy", in_rdy, 2'b00);
      chk("arst_mode_rdy", mode_rdy, 0);
`ifdef INTF_REDUCE_STATS_EN
      chk("arst_fire_count", fire_count, 16'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rel2_in_rdy", in_rdy, 2'b11);
      chk("rel2_mode_rdy", mode_rdy, 1);
      chk("rel2_y_rdy", y_rdy, 0);
      drive(2'b11, 8'h0F, 8'hF1);
      tick();
      pop_check("rel2_mode_or", 8'hFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
